// File: rtl/rgb_hue_sequencer_if.sv
// Control and observation bundle for rgb_hue_sequencer.
// The master drives en/restart; the sequencer (slave) drives the PWM lines and hue position.
interface rgb_hue_sequencer_if #(
  parameter int STEPS_PER_SECTOR = 50
);
  localparam int STEP_W = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;

  // en is a level: it is sampled at every frame boundary. restart is a one-cycle pulse
  // that is latched and acted on at the next frame boundary; no acknowledge is returned.
  logic              en;
  logic              restart;
  logic              pwm_r;
  logic              pwm_g;
  logic              pwm_b;
  logic [2:0]        sector;
  logic [STEP_W-1:0] step;
  logic              frame_start;

  modport master (
    output en, restart,
    input  pwm_r, pwm_g, pwm_b, sector, step, frame_start
  );

  modport slave (
    input  en, restart,
    output pwm_r, pwm_g, pwm_b, sector, step, frame_start
  );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Hue-wheel RGB PWM generator: six sectors of linear duty ramps, with duties shadowed
// per PWM frame so every frame is glitch-free.
module rgb_hue_sequencer #(
  parameter int PWM_INTERVAL     = 1200,
  parameter int STEPS_PER_SECTOR = 50,
  parameter int FRAMES_PER_STEP  = 40
) (
  input  logic               clk,
  input  logic               rst,
  rgb_hue_sequencer_if.slave bus
);
  localparam int CNT_W     = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int DUTY_W    = $clog2(PWM_INTERVAL + 1);
  localparam int STEP_W    = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;
  localparam int DIV_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int DUTY_STEP = PWM_INTERVAL / STEPS_PER_SECTOR;

  localparam logic [DUTY_W-1:0] FULL      = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] DSTEP     = DUTY_W'(DUTY_STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_INTERVAL - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_SECTOR - 1);

  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DIV_W-1:0]  frame_div_q, frame_div_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        sector_q, sector_d;
  logic              restart_pend_q, restart_pend_d;
  logic [DUTY_W-1:0] duty_r_q, duty_r_d;
  logic [DUTY_W-1:0] duty_g_q, duty_g_d;
  logic [DUTY_W-1:0] duty_b_q, duty_b_d;
  logic              pwm_r_q, pwm_r_d;
  logic              pwm_g_q, pwm_g_d;
  logic              pwm_b_q, pwm_b_d;
  logic              frame_start_q, frame_start_d;

  logic              frame_end;
  logic              restart_now;
  logic [DUTY_W-1:0] up, dn;
  logic [DUTY_W-1:0] tgt_r, tgt_g, tgt_b;

  assign frame_end   = (frame_cnt_q == CNT_LAST);
  assign restart_now = restart_pend_q | bus.restart;
  assign up          = DUTY_W'(step_q) * DSTEP;
  assign dn          = FULL - up;

  // Target duties for the current hue position; only sampled into the shadows at frame_end.
  always_comb begin
    tgt_r = '0;
    tgt_g = '0;
    tgt_b = '0;
    case (sector_q)
      3'd0: begin tgt_r = FULL; tgt_g = up;   tgt_b = '0;   end
      3'd1: begin tgt_r = dn;   tgt_g = FULL; tgt_b = '0;   end
      3'd2: begin tgt_r = '0;   tgt_g = FULL; tgt_b = up;   end
      3'd3: begin tgt_r = '0;   tgt_g = dn;   tgt_b = FULL; end
      3'd4: begin tgt_r = up;   tgt_g = '0;   tgt_b = FULL; end
      3'd5: begin tgt_r = FULL; tgt_g = '0;   tgt_b = dn;   end
      default: begin tgt_r = '0; tgt_g = '0; tgt_b = '0; end
    endcase
  end

  always_comb begin
    frame_cnt_d    = frame_end ? '0 : frame_cnt_q + CNT_W'(1);
    frame_div_d    = frame_div_q;
    step_d         = step_q;
    sector_d       = sector_q;
    restart_pend_d = restart_pend_q | bus.restart;
    duty_r_d       = duty_r_q;
    duty_g_d       = duty_g_q;
    duty_b_d       = duty_b_q;

    if (frame_end) begin
      duty_r_d       = tgt_r;
      duty_g_d       = tgt_g;
      duty_b_d       = tgt_b;
      restart_pend_d = 1'b0;
      // A pending (or same-cycle) restart wins over the advance and ignores en.
      if (restart_now) begin
        frame_div_d = '0;
        step_d      = '0;
        sector_d    = '0;
      end else if (bus.en) begin
        if (frame_div_q != DIV_LAST) begin
          frame_div_d = frame_div_q + DIV_W'(1);
        end else begin
          frame_div_d = '0;
          if (step_q == STEP_LAST) begin
            step_d   = '0;
            sector_d = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
    end

    pwm_r_d       = (DUTY_W'(frame_cnt_q) < duty_r_q);
    pwm_g_d       = (DUTY_W'(frame_cnt_q) < duty_g_q);
    pwm_b_d       = (DUTY_W'(frame_cnt_q) < duty_b_q);
    frame_start_d = (frame_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q    <= '0;
      frame_div_q    <= '0;
      step_q         <= '0;
      sector_q       <= '0;
      restart_pend_q <= 1'b0;
      duty_r_q       <= '0;
      duty_g_q       <= '0;
      duty_b_q       <= '0;
      pwm_r_q        <= 1'b0;
      pwm_g_q        <= 1'b0;
      pwm_b_q        <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      frame_div_q    <= frame_div_d;
      step_q         <= step_d;
      sector_q       <= sector_d;
      restart_pend_q <= restart_pend_d;
      duty_r_q       <= duty_r_d;
      duty_g_q       <= duty_g_d;
      duty_b_q       <= duty_b_d;
      pwm_r_q        <= pwm_r_d;
      pwm_g_q        <= pwm_g_d;
      pwm_b_q        <= pwm_b_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign bus.pwm_r       = pwm_r_q;
  assign bus.pwm_g       = pwm_g_q;
  assign bus.pwm_b       = pwm_b_q;
  assign bus.sector      = sector_q;
  assign bus.step        = step_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Self-checking bench for rgb_hue_sequencer using a shrunken wheel (60-cycle frames,
// 5 steps per sector, 3 frames per step) and a frame-level reference model.
module tb_rgb_hue_sequencer;
  localparam int F      = 60;
  localparam int S      = 5;
  localparam int FPS    = 3;
  localparam int DS     = F / S;
  localparam int STEP_W = $clog2(S);

  logic clk;
  logic rst;

  int tests;
  int errors;

  // Reference model: hue position, pending restart and the shadows shown in the current output frame.
  int m_sector, m_step, m_div;
  bit m_pend;
  int m_dr, m_dg, m_db;

  logic [63:0] exp_q[$];

  rgb_hue_sequencer_if #(.STEPS_PER_SECTOR(S)) bus();

  rgb_hue_sequencer #(
    .PWM_INTERVAL    (F),
    .STEPS_PER_SECTOR(S),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void tbl(input int sec, input int stp, output int r, output int g, output int b);
    int up, dn;
    up = stp * DS;
    dn = F - up;
    r = 0; g = 0; b = 0;
    case (sec)
      0: begin r = F;  g = up; b = 0;  end
      1: begin r = dn; g = F;  b = 0;  end
      2: begin r = 0;  g = F;  b = up; end
      3: begin r = 0;  g = dn; b = F;  end
      4: begin r = up; g = 0;  b = F;  end
      5: begin r = F;  g = 0;  b = dn; end
      default: begin r = 0; g = 0; b = 0; end
    endcase
  endfunction

  task automatic model_reset();
    m_sector = 0; m_step = 0; m_div = 0; m_pend = 1'b0;
    m_dr = 0; m_dg = 0; m_db = 0;
  endtask

  // Frame-end update of the model: shadows take the pre-advance position.
  task automatic model_frame_end();
    int nr, ng, nb;
    tbl(m_sector, m_step, nr, ng, nb);
    m_dr = nr; m_dg = ng; m_db = nb;
    if (m_pend) begin
      m_sector = 0; m_step = 0; m_div = 0; m_pend = 1'b0;
    end else if (bus.en) begin
      if (m_div < FPS - 1) m_div++;
      else begin
        m_div = 0;
        if (m_step == S - 1) begin
          m_step = 0;
          m_sector = (m_sector + 1) % 6;
        end else m_step++;
      end
    end
  endtask

  // Driver: one output frame starting at the frame_start sample; optional restart pulse at sample rs_at.
  task automatic run_frame(input int rs_at);
    int cr, cg, cb;
    logic [2:0] s0;
    logic [STEP_W-1:0] t0;
    logic fs_ok;
    logic [63:0] e;
    exp_q.push_back({8'(m_sector), 8'(m_step), 16'(m_dr), 16'(m_dg), 16'(m_db)});
    cr = 0; cg = 0; cb = 0; fs_ok = 1'b1;
    s0 = '0; t0 = '0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (i == 0) begin
        s0 = bus.sector;
        t0 = bus.step;
      end
      bus.restart = (i == rs_at);
      if (i == rs_at) m_pend = 1'b1;
      cr += int'(bus.pwm_r);
      cg += int'(bus.pwm_g);
      cb += int'(bus.pwm_b);
      if (bus.frame_start !== (i == 0)) fs_ok = 1'b0;
      if (i == F - 2) begin
        chk("sector_hold", 32'(bus.sector), 32'(m_sector));
        chk("step_hold", 32'(bus.step), 32'(m_step));
      end
      if (i == F - 1) begin
        model_frame_end();
        chk("sector_adv", 32'(bus.sector), 32'(m_sector));
        chk("step_adv", 32'(bus.step), 32'(m_step));
      end
    end
    e = exp_q.pop_front();
    chk("frame_start", 32'(fs_ok), 32'd1);
    chk("sector_at_start", 32'(s0), 32'(e[63:56]));
    chk("step_at_start", 32'(t0), 32'(e[55:48]));
    chk("r_high_cycles", 32'(cr), 32'(e[47:32]));
    chk("g_high_cycles", 32'(cg), 32'(e[31:16]));
    chk("b_high_cycles", 32'(cb), 32'(e[15:0]));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pwm_r"}, 32'(bus.pwm_r), 32'd0);
    chk({tag, "_pwm_g"}, 32'(bus.pwm_g), 32'd0);
    chk({tag, "_pwm_b"}, 32'(bus.pwm_b), 32'd0);
    chk({tag, "_sector"}, 32'(bus.sector), 32'd0);
    chk({tag, "_step"}, 32'(bus.step), 32'd0);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
  endtask

  initial begin
    tests = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.restart = 1'b0;

    // Reset, then frame 0 dark and frame 1 full red
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    run_frame(-1);
    run_frame(-1);

    // Full wheel with en=1: step ramps, sector wraps 0..5 and back to 0
    for (int k = 0; k < 6 * S * FPS + 4; k++) run_frame(-1);

    // Freeze mid-sector for 100 frames
    for (int k = 0; k < 4; k++) run_frame(-1);
    bus.en = 1'b0;
    for (int k = 0; k < 100; k++) run_frame(-1);
    bus.en = 1'b1;
    for (int k = 0, n = $urandom_range(1, 10); k < n; k++) run_frame(-1);

    // Restart mid-frame in sector 3, step 2
    for (int k = 0; k < 200 && !(m_sector == 3 && m_step == 2); k++) run_frame(-1);
    chk("reach_s3_a", 32'(bus.sector), 32'd3);
    run_frame($urandom_range(1, F - 3));
    run_frame(-1);
    run_frame(-1);

    // Restart with en=0, pulse in the frame_end cycle itself
    for (int k = 0; k < 200 && !(m_sector == 3 && m_step == 2); k++) run_frame(-1);
    chk("reach_s3_b", 32'(bus.sector), 32'd3);
    bus.en = 1'b0;
    run_frame(F - 2);
    run_frame(-1);
    run_frame(-1);

    // Asynchronous reset mid-frame while pwm_r is high
    repeat (10) @(negedge clk);
    chk("pwm_r_before_rst", 32'(bus.pwm_r), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    repeat (2) @(negedge clk);
    check_reset_state("rst_held");
    model_reset();
    bus.en = 1'b1;
    rst = 1'b0;
    run_frame(-1);
    run_frame(-1);
    run_frame(-1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
